// File: rtl/fir_sample_feeder.sv
// Sample FIFO in front of the FIR filter. Samples arrive from a ready/valid source and
// leave at a programmable rate, one single-cycle strobe per period.
module fir_sample_feeder #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int DIV_W  = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       s_valid_i,
   input  logic [DATA_W-1:0]          s_data_i,
   output logic                       s_ready_o,
   input  logic                       enable_i,
   input  logic [DIV_W-1:0]           rate_div_i,
   input  logic                       clear_underrun_i,
   output logic                       valid_strobe_o,
   output logic [DATA_W-1:0]          data_o,
   output logic [$clog2(DEPTH+1)-1:0] fill_o,
   output logic                       underrun_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;
   logic [FW-1:0]     fill_reg;
   logic [DIV_W-1:0]  cnt_reg;
   logic              strobe_reg;
   logic [DATA_W-1:0] data_reg;
   logic              underrun_reg;

   logic full;
   logic empty;
   logic push;
   logic tick;
   logic pop;

   // Ready depends on registered occupancy only, so a same-cycle pop never frees a slot.
   assign full  = (fill_reg == FW'(DEPTH));
   assign empty = (fill_reg == '0);
   assign push  = s_valid_i && !full;
   assign tick  = enable_i && (cnt_reg == '0);
   assign pop   = tick && !empty;

   assign s_ready_o      = !full;
   assign valid_strobe_o = strobe_reg;
   assign data_o         = data_reg;
   assign fill_o         = fill_reg;
   assign underrun_o     = underrun_reg;

   // Storage is left unreset so it can map onto block RAM.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr_reg] <= s_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         fill_reg   <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   fill_reg <= fill_reg + FW'(1);
            2'b01:   fill_reg <= fill_reg - FW'(1);
            default: fill_reg <= fill_reg;
         endcase
      end
   end

   // The divisor is only sampled on reload, so a mid-period change takes effect next period.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_reg <= '0;
      end else if (!enable_i) begin
         cnt_reg <= '0;
      end else if (tick) begin
         cnt_reg <= rate_div_i;
      end else begin
         cnt_reg <= cnt_reg - DIV_W'(1);
      end
   end

   // An empty tick still strobes (with zero data) so the filter's timing never slips.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         strobe_reg   <= 1'b0;
         data_reg     <= '0;
         underrun_reg <= 1'b0;
      end else begin
         strobe_reg <= tick;
         if (tick) begin
            data_reg <= pop ? mem[rd_ptr_reg] : '0;
         end
         if (tick && empty) begin
            underrun_reg <= 1'b1;
         end else if (clear_underrun_i) begin
            underrun_reg <= 1'b0;
         end
      end
   end

endmodule
